draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_draw_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_arbiter.sv
// Round-robin arbiter that rasterises one requester's rectangle at a time into a pixel stream.
// Latency: LOAD the cycle after the request is seen, first pixel one cycle later, done after w*h pixels.
// Backpressure: none downstream; requesters hold req until done and wait while busy, with no pre-emption.
module draw_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [14:0] req_w,
  input  logic [14:0] req_h,
  input  logic [8:0]  req_col,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        plot,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  last_served;
  logic [1:0]  winner;
  logic [1:0]  rr_pick;
  logic [1:0]  cand0;
  logic [1:0]  cand1;
  logic [1:0]  cand2;

  // Latched rectangle of the requester being served.
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [4:0]  w0;
  logic [4:0]  h0;
  logic [2:0]  col0;

  // Winner's live operands, only meaningful in LOAD.
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [4:0]  sel_w;
  logic [4:0]  sel_h;
  logic [2:0]  sel_col;

  logic [4:0]  cx;
  logic [4:0]  cy;
  logic        last_col;
  logic        last_row;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin pick: search starts just after the last requester served.
  always_comb begin
    cand0   = next_idx(last_served);
    cand1   = next_idx(cand0);
    cand2   = next_idx(cand1);
    rr_pick = cand2;
    if (req[cand0]) begin
      rr_pick = cand0;
    end else if (req[cand1]) begin
      rr_pick = cand1;
    end
  end

  // Mux out the winning requester's operand slices.
  always_comb begin
    sel_x   = req_x[7:0];
    sel_y   = req_y[6:0];
    sel_w   = req_w[4:0];
    sel_h   = req_h[4:0];
    sel_col = req_col[2:0];
    case (winner)
      2'd1: begin
        sel_x   = req_x[15:8];
        sel_y   = req_y[13:7];
        sel_w   = req_w[9:5];
        sel_h   = req_h[9:5];
        sel_col = req_col[5:3];
      end
      2'd2: begin
        sel_x   = req_x[23:16];
        sel_y   = req_y[20:14];
        sel_w   = req_w[14:10];
        sel_h   = req_h[14:10];
        sel_col = req_col[8:6];
      end
      default: ;
    endcase
  end

  // Raster position and end-of-row / end-of-rectangle detection.
  always_comb begin
    x_sum    = {1'b0, x0} + {4'b0, cx};
    y_sum    = {1'b0, y0} + {3'b0, cy};
    last_col = (cx == (w0 - 5'd1));
    last_row = (cy == (h0 - 5'd1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req != 3'b000) state_nxt = LOAD;
      LOAD: state_nxt = ((sel_w == 5'd0) || (sel_h == 5'd0)) ? DONE : DRAW;
      DRAW: if (last_col && last_row) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration bookkeeping, operand capture and raster counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_served <= 2'd2;
      winner      <= 2'd0;
      x0          <= 8'd0;
      y0          <= 7'd0;
      w0          <= 5'd0;
      h0          <= 5'd0;
      col0        <= 3'd0;
      cx          <= 5'd0;
      cy          <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 3'b000) winner <= rr_pick;
        end
        LOAD: begin
          x0   <= sel_x;
          y0   <= sel_y;
          w0   <= sel_w;
          h0   <= sel_h;
          col0 <= sel_col;
          cx   <= 5'd0;
          cy   <= 5'd0;
        end
        DRAW: begin
          if (last_col) begin
            cx <= 5'd0;
            if (!last_row) cy <= cy + 5'd1;
          end else begin
            cx <= cx + 5'd1;
          end
        end
        DONE: begin
          last_served <= winner;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; clipped pixels keep their cycle but drop plot.
  always_comb begin
    gnt        = 3'b000;
    done       = 3'b000;
    plot       = 1'b0;
    x_out      = 8'd0;
    y_out      = 7'd0;
    colour_out = 3'd0;
    busy       = (state != IDLE);
    case (state)
      LOAD: gnt = 3'b001 << winner;
      DRAW: begin
        gnt        = 3'b001 << winner;
        plot       = (int'(x_sum) < SCREEN_W) && (int'(y_sum) < SCREEN_H);
        x_out      = x_sum[7:0];
        y_out      = y_sum[6:0];
        colour_out = col0;
      end
      DONE: done = 3'b001 << winner;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: transaction-level model predicting every output cycle, plus directed scenarios.
// Latency: model schedules LOAD, w*h pixels, DONE and one idle cycle per granted rectangle.
// Backpressure: requesters hold req and operands until their done pulse.
module tb_draw_arbiter;

  localparam int SW = 160;
  localparam int SH = 120;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [14:0] req_w;
  logic [14:0] req_h;
  logic [8:0]  req_col;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        plot;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  draw_arbiter #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_col(req_col), .gnt(gnt), .done(done),
    .plot(plot), .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       busy;
  } out_t;

  // Behavioural model: once a winner is chosen, the whole transaction is queued cycle by cycle.
  out_t exp_q[$];
  out_t exp_cur;
  out_t e;
  bit   model_ok = 0;
  bit   pending  = 0;
  int   m_last   = 2;
  int   m_win    = 0;
  int   mx, my, mw, mh, mc, xs, ys;

  always @(posedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      pending  = 0;
      m_last   = 2;
      exp_cur  = '0;
      model_ok = 1;
    end else if (pending) begin
      mx = int'(req_x[m_win*8 +: 8]);
      my = int'(req_y[m_win*7 +: 7]);
      mw = int'(req_w[m_win*5 +: 5]);
      mh = int'(req_h[m_win*5 +: 5]);
      mc = int'(req_col[m_win*3 +: 3]);
      for (int r = 0; r < mh; r++) begin
        for (int c = 0; c < mw; c++) begin
          xs     = mx + c;
          ys     = my + r;
          e      = '0;
          e.gnt  = 3'(1 << m_win);
          e.busy = 1'b1;
          e.plot = (xs < SW) && (ys < SH);
          e.x    = 8'(xs);
          e.y    = 7'(ys);
          e.col  = 3'(mc);
          exp_q.push_back(e);
        end
      end
      e      = '0;
      e.done = 3'(1 << m_win);
      e.busy = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back('0);
      m_last  = m_win;
      pending = 0;
      exp_cur = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
    end else if (req != 3'b000) begin
      m_win = -1;
      for (int k = 1; k <= 3; k++) begin
        if (m_win < 0 && req[(m_last + k) % 3]) m_win = (m_last + k) % 3;
      end
      exp_cur      = '0;
      exp_cur.gnt  = 3'(1 << m_win);
      exp_cur.busy = 1'b1;
      pending      = 1;
    end else begin
      exp_cur = '0;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (model_ok) begin
      total++;
      if ({gnt, done, plot, x_out, y_out, colour_out, busy} !== exp_cur) begin
        bad++;
        $display("FAIL cycle_model t=%0t got=%h want=%h", $time,
                 {gnt, done, plot, x_out, y_out, colour_out, busy}, exp_cur);
      end
      total++;
      if (!$onehot0(gnt)) begin
        bad++;
        $display("FAIL gnt_onehot t=%0t got=%b want=one-hot or zero", $time, gnt);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  logic [14:0] pix_q[$];

  task automatic set_ops(input int i, input int x, input int y, input int w, input int h, input int col);
    req_x[i*8 +: 8]   = 8'(x);
    req_y[i*7 +: 7]   = 7'(y);
    req_w[i*5 +: 5]   = 5'(w);
    req_h[i*5 +: 5]   = 5'(h);
    req_col[i*3 +: 3] = 3'(col);
  endtask

  // Serve one rectangle; k counts cycles after the sampling edge (k=0 is LOAD).
  task automatic run_rect(input int i, input int x, input int y, input int w, input int h,
                          input int col, input int drop_k, output int gcnt, output int dk);
    set_ops(i, x, y, w, h, col);
    req[i] = 1'b1;
    @(posedge clk);
    gcnt = 0;
    dk   = -1;
    pix_q.delete();
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (gnt[i]) gcnt++;
      if (plot) pix_q.push_back({x_out, y_out});
      if (k == drop_k) begin
        req[i] = 1'b0;
        set_ops(i, $urandom_range(0, 255), $urandom_range(0, 127), 9, 9, $urandom_range(0, 7));
      end
      if (done[i]) begin
        dk     = k;
        req[i] = 1'b0;
        break;
      end
    end
    if (dk < 0) chk("rect_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk(nm, 0, 1);
  endtask

  function automatic logic [14:0] pxy(input int x, input int y);
    return {8'(x), 7'(y)};
  endfunction

  int gcnt, dk, ndone;
  logic [14:0] wantp[4];
  logic [2:0]  order[$];
  logic [2:0]  prev_g;

  initial begin
    resetn = 1'b0; req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_col = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({gnt, done, plot, x_out, y_out, colour_out, busy}), 0);
    resetn = 1'b1;
    @(negedge clk);

    // 2x2 at (10,5): LOAD + 4 pixels granted, done in the DONE cycle at k=5.
    run_rect(0, 10, 5, 2, 2, 3, -1, gcnt, dk);
    chk("s036_gnt_cycles", gcnt, 5);
    chk("s036_done_k", dk, 5);
    chk("s036_npix", pix_q.size(), 4);
    wantp[0] = pxy(10, 5); wantp[1] = pxy(11, 5); wantp[2] = pxy(10, 6); wantp[3] = pxy(11, 6);
    for (int j = 0; j < 4 && j < pix_q.size(); j++) chk("s036_pix", int'(pix_q[j]), int'(wantp[j]));
    @(negedge clk);

    // Clipped 4x2 at the bottom-right corner: 8 DRAW cycles, two visible pixels.
    run_rect(1, 158, 119, 4, 2, 5, -1, gcnt, dk);
    chk("s038_gnt_cycles", gcnt, 9);
    chk("s038_done_k", dk, 9);
    chk("s038_npix", pix_q.size(), 2);
    wantp[0] = pxy(158, 119); wantp[1] = pxy(159, 119);
    for (int j = 0; j < 2 && j < pix_q.size(); j++) chk("s038_pix", int'(pix_q[j]), int'(wantp[j]));
    @(negedge clk);

    // Zero-width rectangle: straight from LOAD to DONE.
    run_rect(2, 40, 40, 0, 7, 1, -1, gcnt, dk);
    chk("s039_npix", pix_q.size(), 0);
    chk("s039_done_k", dk, 1);
    @(negedge clk);

    // 3x1 with req dropped and operands scrambled during DRAW.
    run_rect(0, 20, 30, 3, 1, 6, 1, gcnt, dk);
    chk("s041_npix", pix_q.size(), 3);
    chk("s041_done_k", dk, 4);
    wantp[0] = pxy(20, 30); wantp[1] = pxy(21, 30); wantp[2] = pxy(22, 30);
    for (int j = 0; j < 3 && j < pix_q.size(); j++) chk("s041_pix", int'(pix_q[j]), int'(wantp[j]));
    @(negedge clk);

    // Reset in the 3rd DRAW cycle of a 4x4 rectangle aborts it silently.
    set_ops(0, 50, 50, 4, 4, 2);
    req[0] = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    req    = '0;
    @(negedge clk);
    chk("s040_zero", int'({gnt, done, plot, x_out, y_out, colour_out, busy}), 0);
    resetn = 1'b1;
    ndone  = 0;
    repeat (30) begin
      @(negedge clk);
      if (done != 3'b000) ndone++;
    end
    chk("s040_no_done", ndone, 0);

    // All three held: order 0,1,2,0 starting from reset.
    for (int i = 0; i < 3; i++) set_ops(i, 5 * i, 7, 1 + i, 1, i);
    req    = 3'b111;
    prev_g = 3'b000;
    order.delete();
    for (int n = 0; n < 200 && order.size() < 4; n++) begin
      @(negedge clk);
      if (gnt != 3'b000 && prev_g == 3'b000) order.push_back(gnt);
      prev_g = gnt;
    end
    req = 3'b000;
    chk("s037_nserv", order.size(), 4);
    wantp[0] = 15'd1; wantp[1] = 15'd2; wantp[2] = 15'd4; wantp[3] = 15'd1;
    for (int j = 0; j < 4 && j < order.size(); j++) chk("s037_order", int'(order[j]), int'(wantp[j]));
    wait_idle("s037_idle_timeout");
    @(negedge clk);

    // Random traffic: each requester holds until its done, then may re-request.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i] || (!req[i] && ($urandom_range(0, 3) == 0))) begin
          req[i] = 1'($urandom_range(0, 1));
          set_ops(i, $urandom_range(0, 255), $urandom_range(0, 127),
                  $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 7));
        end
      end
      @(negedge clk);
    end
    req = 3'b000;
    wait_idle("rand_idle_timeout");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
